// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register-file write arbiter.
//   REG_ADDR_W / REG_DATA_W : register index and data widths of the 32x32 file
//   REG_ZERO                : index of the hard-wired zero register
//   port_e                  : identifies a writeback source (ALU = A, load = B)
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

endpackage

// File: rtl/rf_wr_slot.sv
// rf_wr_slot: one-entry holding buffer for a writeback source.
//   clk, rst          : clock, synchronous active-high reset
//   valid_i, ready_o  : request handshake (accepted when both high at posedge)
//   addr_i, data_i    : destination register and write data
//   grant_i           : this slot wins the write port this cycle
//   other_keep_i      : the other slot is valid and stays valid across this edge
//   other_grant_i     : the other slot wins the write port this cycle
//   valid_o, addr_o,
//   data_o            : slot contents
//   young_o           : slot was filled behind a still-pending entry in the other slot
module rf_wr_slot
  import rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              grant_i,
  input  logic              other_keep_i,
  input  logic              other_grant_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              young_o
);

  logic              valid_q, valid_d;
  logic              young_q, young_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              fill;

  // Draining and refilling in the same cycle keeps an uncontested port at one write per cycle.
  assign ready_o = !valid_q || grant_i;

  // Writes to the zero register complete the handshake but are never stored.
  assign fill = valid_i && ready_o && (addr_i != '0);

  always_comb begin
    valid_d = valid_q;
    young_d = young_q;
    if (fill) begin
      valid_d = 1'b1;
      // Younger only if the other entry was already waiting and survives this edge;
      // two entries landing on the same edge are equal in age.
      young_d = other_keep_i;
    end else begin
      if (grant_i) valid_d = 1'b0;
      // Losing entry becomes the oldest once the other slot drains.
      if (grant_i || other_grant_i) young_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      young_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      young_q <= young_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fill) begin
      addr_q <= addr_i;
      data_q <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign young_o = young_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register file's single write port between the
// ALU writeback (port A) and the load writeback (port B).
//   clk, rst                         : clock, synchronous active-high reset
//   a_valid/a_ready/a_addr/a_data    : ALU writeback request
//   b_valid/b_ready/b_addr/b_data    : load writeback request
//   RegWrite, rc, dc                 : registered write enable / index / data to the file
//   hz_addr, hz_pending              : decode read-hazard query (combinational)
//   conflict_cnt                     : saturating count of cycles with both slots full
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = REG_DATA_W,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] rc,
  output logic [DATA_W-1:0] dc,
  input  logic [ADDR_W-1:0] hz_addr,
  output logic              hz_pending,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              sa_valid, sb_valid;
  logic              sa_young, sb_young;
  logic [ADDR_W-1:0] sa_addr, sb_addr;
  logic [DATA_W-1:0] sa_data, sb_data;

  logic              gnt_a, gnt_b, tie;
  port_e             rr_q, rr_d;

  logic              we_q;
  logic [ADDR_W-1:0] rc_q, rc_d;
  logic [DATA_W-1:0] dc_q, dc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (a_valid),
    .ready_o      (a_ready),
    .addr_i       (a_addr),
    .data_i       (a_data),
    .grant_i      (gnt_a),
    .other_keep_i (sb_valid && !gnt_b),
    .other_grant_i(gnt_b),
    .valid_o      (sa_valid),
    .addr_o       (sa_addr),
    .data_o       (sa_data),
    .young_o      (sa_young)
  );

  rf_wr_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (b_valid),
    .ready_o      (b_ready),
    .addr_i       (b_addr),
    .data_i       (b_data),
    .grant_i      (gnt_b),
    .other_keep_i (sa_valid && !gnt_a),
    .other_grant_i(gnt_a),
    .valid_o      (sb_valid),
    .addr_o       (sb_addr),
    .data_o       (sb_data),
    .young_o      (sb_young)
  );

  // Grant: oldest entry first; equal age resolved by the round-robin pointer.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    tie   = 1'b0;
    if (sa_valid && sb_valid) begin
      if (sa_young && !sb_young) begin
        gnt_b = 1'b1;
      end else if (sb_young && !sa_young) begin
        gnt_a = 1'b1;
      end else begin
        tie = 1'b1;
        if (rr_q == PORT_A) gnt_a = 1'b1;
        else                gnt_b = 1'b1;
      end
    end else if (sa_valid) begin
      gnt_a = 1'b1;
    end else if (sb_valid) begin
      gnt_b = 1'b1;
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (tie) rr_d = (rr_q == PORT_A) ? PORT_B : PORT_A;
  end

  always_comb begin
    rc_d = rc_q;
    dc_d = dc_q;
    if (gnt_a) begin
      rc_d = sa_addr;
      dc_d = sa_data;
    end else if (gnt_b) begin
      rc_d = sb_addr;
      dc_d = sb_data;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (sa_valid && sb_valid && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  // Output stage: one registered write per granted cycle; a reset edge never emits a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q  <= PORT_A;
      we_q  <= 1'b0;
      rc_q  <= '0;
      dc_q  <= '0;
      cnt_q <= '0;
    end else begin
      rr_q  <= rr_d;
      we_q  <= gnt_a || gnt_b;
      rc_q  <= rc_d;
      dc_q  <= dc_d;
      cnt_q <= cnt_d;
    end
  end

  // A write is in flight while it sits in a slot or is being presented to the file.
  assign hz_pending = (hz_addr != '0) &&
                      ((sa_valid && (sa_addr == hz_addr)) ||
                       (sb_valid && (sb_addr == hz_addr)) ||
                       (we_q && (rc_q == hz_addr)));

  assign RegWrite     = we_q;
  assign rc           = rc_q;
  assign dc           = dc_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, hz_addr, rc;
  logic [31:0] a_data, b_data, dc;
  logic        RegWrite, hz_pending;
  logic [15:0] conflict_cnt;

  rf_write_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_addr      (a_addr),
    .a_data      (a_data),
    .b_valid     (b_valid),
    .b_ready     (b_ready),
    .b_addr      (b_addr),
    .b_data      (b_data),
    .RegWrite    (RegWrite),
    .rc          (rc),
    .dc          (dc),
    .hz_addr     (hz_addr),
    .hz_pending  (hz_pending),
    .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  passes = 0;
  bit  mon_en = 1'b0;

  // Reference model: pending writes tagged with the cycle they were accepted.
  bit          m_v[2];
  logic [4:0]  m_addr[2];
  logic [31:0] m_data[2];
  int          m_stamp[2];
  int          m_rr;          // 0 = port A, 1 = port B
  int          m_cnt;
  bit          m_we;
  logic [4:0]  m_wa;
  int          cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    m_v[0] = 0; m_v[1] = 0;
    m_rr = 0; m_cnt = 0; m_we = 0; m_wa = '0;
  endtask

  // One clock cycle: drive inputs, check combinational/registered outputs
  // against the model, then advance the model across the coming edge.
  task automatic step(input bit av, input logic [4:0] aa, input logic [31:0] ad,
                      input bit bv, input logic [4:0] ba, input logic [31:0] bd,
                      input logic [4:0] hz, input bit r);
    int  g;
    bit  tie, rdy0, rdy1, hz_exp;
    @(negedge clk);
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    hz_addr = hz; rst = r;
    #1;
    g = -1; tie = 0;
    if (m_v[0] && m_v[1]) begin
      if (m_stamp[0] < m_stamp[1])      g = 0;
      else if (m_stamp[1] < m_stamp[0]) g = 1;
      else begin g = m_rr; tie = 1; end
    end else if (m_v[0]) g = 0;
    else if (m_v[1])     g = 1;
    rdy0 = !m_v[0] || (g == 0);
    rdy1 = !m_v[1] || (g == 1);
    if (!r) begin
      hz_exp = (hz != 0) && ((m_v[0] && m_addr[0] == hz) || (m_v[1] && m_addr[1] == hz) ||
                             (m_we && m_wa == hz));
      chk("a_ready", a_ready, rdy0);
      chk("b_ready", b_ready, rdy1);
      chk("hz_pending", hz_pending, hz_exp);
      chk("conflict_cnt", conflict_cnt, m_cnt);
    end
    if (r) begin
      model_reset();
    end else begin
      if (g >= 0) begin
        exp_q.push_back({m_addr[g], m_data[g]});
        m_we = 1; m_wa = m_addr[g];
      end else begin
        m_we = 0;
      end
      if (m_v[0] && m_v[1] && m_cnt < 65535) m_cnt++;
      if (tie) m_rr = 1 - m_rr;
      if (g >= 0) m_v[g] = 0;
      if (av && rdy0 && aa != 0) begin m_v[0] = 1; m_addr[0] = aa; m_data[0] = ad; m_stamp[0] = cyc; end
      if (bv && rdy1 && ba != 0) begin m_v[1] = 1; m_addr[1] = ba; m_data[1] = bd; m_stamp[1] = cyc; end
    end
    cyc++;
  endtask

  task automatic idle(input logic [4:0] hz);
    step(0, 0, 0, 0, 0, 0, hz, 0);
  endtask

  // Monitor: every presented write must match the next expected write in order.
  always @(negedge clk) begin
    if (mon_en && RegWrite) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {rc, dc}, 0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("rc", rc, e.addr);
        chk("dc", dc, e.data);
      end
    end
  end

  initial begin
    rst = 1; a_valid = 0; b_valid = 0; a_addr = 0; b_addr = 0;
    a_data = 0; b_data = 0; hz_addr = 0;
    model_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    mon_en = 1'b1;

    // Reset state
    @(negedge clk); #1;
    chk("rst_RegWrite", RegWrite, 0);
    chk("rst_rc", rc, 0);
    chk("rst_dc", dc, 0);
    chk("rst_cnt", conflict_cnt, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_b_ready", b_ready, 1);

    // Single write r5 with the hazard query watching r5
    step(1, 5, 32'h1234, 0, 0, 0, 5, 0);
    idle(5); idle(5); idle(5);

    // Zero-register drop
    step(1, 0, 32'hFFFF, 0, 0, 0, 0, 0);
    idle(0); idle(0);

    // Same-edge pairs twice: round-robin order flips
    step(1, 3, 1, 1, 4, 2, 3, 0);
    idle(4); idle(4);
    step(1, 3, 1, 1, 4, 2, 4, 0);
    idle(3); idle(3);

    // Age ordering on a shared destination
    step(1, 9, 32'h99, 0, 0, 0, 7, 0);
    step(1, 10, 32'h10, 1, 7, 32'hAA, 7, 0);
    step(1, 7, 32'hBB, 0, 0, 0, 7, 0);
    idle(7); idle(7); idle(7); idle(7);

    // Back-to-back ALU writes r1..r8
    for (int i = 1; i <= 8; i++) step(1, 5'(i), 32'h100 + i, 0, 0, 0, 5'(i), 0);
    idle(8); idle(8);

    // Reset with both slots full
    step(1, 11, 32'hA11, 1, 12, 32'hB12, 11, 0);
    step(1, 13, 32'hA13, 1, 14, 32'hB14, 12, 0);
    step(0, 0, 0, 0, 0, 0, 13, 1);
    idle(13); idle(14); idle(0);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
    end
    for (int i = 0; i < 4; i++) idle(0);
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter for the 32×32 register file. Two writeback sources share the file's single write port (RegWrite/rc/dc): the ALU writeback (port A) and the load/memory writeback (port B). Each source has a one-entry holding slot with a valid/ready handshake. Arbitration is oldest-first, with a round-robin tie-break. A hazard query reports whether a register still has a write in flight, so decode can stall reads of it.

## Interface
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width
- CNT_W, 16, conflict-counter width
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  ALU write request
- a_ready  out  1  port A can accept this cycle
- a_addr  in  ADDR_W  destination register
- a_data  in  DATA_W  write data
- b_valid, b_ready, b_addr, b_data: same as port A, for the load/memory source
- RegWrite  out  1  register-file write enable (registered)
- rc  out  ADDR_W  register-file write index (registered)
- dc  out  DATA_W  register-file write data (registered)
- hz_addr  in  ADDR_W  register being read by decode
- hz_pending  out  1  a write to hz_addr is in flight (combinational)
- conflict_cnt  out  CNT_W  saturating count of contended cycles

## Operation
- A request is accepted when x_valid && x_ready at posedge.
  - Accepted addr/data are captured into slot x.
  - Each slot carries an age flag, set when that slot is filled while the other slot is already valid; the filled slot is then marked younger.
- A request with x_addr==0 is accepted but dropped (never stored), because writes to $zero are discarded.
- Grant is combinational each cycle from slot state:
  - Only one slot valid: that slot wins.
  - Both valid, different ages: the older slot wins.
  - Both valid, filled in the same cycle: the slot named by rr_ptr wins. rr_ptr then toggles to the other port.
- On the posedge with a grant:
  - RegWrite<=1, rc<=winner addr, dc<=winner data.
  - The winner's slot is cleared.
  - The loser, if present, becomes oldest.
- With no grant: RegWrite<=0; rc and dc hold their values.
- x_ready = !slot_x_valid || grant_x. A port can therefore refill its slot in the same cycle it drains, giving 1 write/cycle when uncontested.
- hz_pending = (hz_addr!=0) && any of:
  - slot A is valid with addr==hz_addr
  - slot B is valid with addr==hz_addr
  - RegWrite && rc==hz_addr
- conflict_cnt increments on each cycle where both slots are valid. It saturates at all-ones.

## Timing
- Reset values:
  - slots empty, age flags clear, rr_ptr=A
  - RegWrite=0, rc=0, dc=0, conflict_cnt=0
  - a_ready=b_ready=1 in the first cycle after reset
- Latency, uncontested:
  - accept at edge N
  - RegWrite/rc/dc valid during cycle N+1
  - register file updated at edge N+2
- Contested loser: granted one cycle later than the winner. Its x_ready stays 0 until the grant cycle.
- Same address in both slots: the older write lands first, so the younger value is final. On a same-cycle tie, the rr_ptr order decides.
- x_valid may drop without acceptance; there is no requirement to hold it.
- rst asserted mid-operation: pending slot contents are discarded and no RegWrite pulse occurs on the reset edge or after it. Any write already presented in the current cycle completes at the register file, which is not under reset.
- hz_pending goes low the cycle after the write is presented (edge N+2 onward for the uncontested case).

## Structure
- rf_pkg holds:
  - REG_ADDR_W=5, REG_DATA_W=32, REG_ZERO=5'd0
  - port-id enum PORT_A/PORT_B, used for rr_ptr and the grant
- Sub-module rf_wr_slot is a one-entry holding buffer with a valid/ready handshake, an age flag and a zero-address drop. It is instantiated once per port.
- The top level contains the grant logic, rr_ptr, the output registers, the hazard compare and the counter.

## Test plan
- Single write: A writes r5=0x1234 at edge N.
  - Expect RegWrite=1, rc=5, dc=0x1234 during cycle N+1.
  - hz_pending(5) is high in cycles N and N+1, then low.
- Zero drop: A writes r0=0xFFFF.
  - Expect a_ready=1, RegWrite stays 0 and hz_pending(0)=0.
- Tie and round-robin: A (r3=1) and B (r4=2) are accepted on the same edge, twice in succession.
  - First pair: A then B.
  - Second pair: B then A.
  - conflict_cnt increments once per contended cycle.
- Age ordering: B writes r7=0xAA at edge N, then A writes r7=0xBB at edge N+1 while B is still pending behind an earlier A.
  - Final rc=7 writes arrive in the order 0xAA then 0xBB.
- Back-to-back: A issues r1..r8 on consecutive cycles with B idle.
  - a_ready stays 1 throughout.
  - Eight consecutive RegWrite cycles with rc=1..8.
- Reset mid-flight: both slots are full and rst is asserted for one cycle.
  - RegWrite=0 from the next cycle onward.
  - Both readys=1 and conflict_cnt=0.
  - No stale write after reset.
